// File: rtl/vpu_pkg.sv
// Shared state encoding and default geometry for the rectangle filler.
package vpu_pkg;

  localparam int unsigned VPU_X_BITS     = 8;
  localparam int unsigned VPU_Y_BITS     = 8;
  localparam int unsigned VPU_COLOR_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } vpu_state_e;

endpackage

// File: rtl/vpu_span_counter.sv
// Column/row walker for a rectangle: reloads the column at each row end,
// wraps both fields independently, and flags the final pixel.
module vpu_span_counter
  import vpu_pkg::*;
#(
  parameter int unsigned X_BITS = VPU_X_BITS,
  parameter int unsigned Y_BITS = VPU_Y_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [X_BITS-1:0] start_x,
  input  logic [Y_BITS-1:0] start_y,
  input  logic [X_BITS-1:0] width,
  input  logic [Y_BITS-1:0] height,
  input  logic              step,
  output logic [X_BITS-1:0] col,
  output logic [Y_BITS-1:0] row,
  output logic              last
);

  logic [X_BITS-1:0] col_q, col_d;
  logic [Y_BITS-1:0] row_q, row_d;
  logic [X_BITS-1:0] x0_q, x0_d;
  logic [X_BITS-1:0] wm1_q, wm1_d;
  logic [X_BITS-1:0] xrem_q, xrem_d;
  logic [Y_BITS-1:0] yrem_q, yrem_d;

  // Remaining-count registers hold (count - 1), so zero marks the row/rect end.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    x0_d   = x0_q;
    wm1_d  = wm1_q;
    xrem_d = xrem_q;
    yrem_d = yrem_q;
    if (load) begin
      col_d  = start_x;
      row_d  = start_y;
      x0_d   = start_x;
      wm1_d  = width - X_BITS'(1);
      xrem_d = width - X_BITS'(1);
      yrem_d = height - Y_BITS'(1);
    end else if (step) begin
      if (xrem_q == '0) begin
        col_d  = x0_q;
        row_d  = row_q + Y_BITS'(1);
        xrem_d = wm1_q;
        yrem_d = yrem_q - Y_BITS'(1);
      end else begin
        col_d  = col_q + X_BITS'(1);
        xrem_d = xrem_q - X_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      x0_q   <= '0;
      wm1_q  <= '0;
      xrem_q <= '0;
      yrem_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      x0_q   <= x0_d;
      wm1_q  <= wm1_d;
      xrem_q <= xrem_d;
      yrem_q <= yrem_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (xrem_q == '0) && (yrem_q == '0);

endmodule

// File: rtl/vpu_rect_filler.sv
// Rectangle fill engine emitting one frame-buffer write per handshake.
// Optional checkerboard fill is enabled by defining VPU_FILL_PATTERN_EN.
module vpu_rect_filler
  import vpu_pkg::*;
#(
  parameter int unsigned X_BITS     = VPU_X_BITS,
  parameter int unsigned Y_BITS     = VPU_Y_BITS,
  parameter int unsigned COLOR_BITS = VPU_COLOR_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [X_BITS-1:0]        cmd_x,
  input  logic [Y_BITS-1:0]        cmd_y,
  input  logic [X_BITS-1:0]        cmd_w,
  input  logic [Y_BITS-1:0]        cmd_h,
  input  logic [COLOR_BITS-1:0]    cmd_color,
`ifdef VPU_FILL_PATTERN_EN
  input  logic [COLOR_BITS-1:0]    cmd_color2,
  input  logic                     cmd_pattern,
`endif
  input  logic                     cmd_abort,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [Y_BITS+X_BITS-1:0] wr_addr,
  output logic [COLOR_BITS-1:0]    wr_data,
  output logic                     busy,
  output logic                     done
);

  vpu_state_e state_q, state_d;
  logic [COLOR_BITS-1:0] color_q, color_d;
`ifdef VPU_FILL_PATTERN_EN
  logic [COLOR_BITS-1:0] color2_q, color2_d;
  logic                  pattern_q, pattern_d;
`endif

  logic              load;
  logic              step;
  logic              last;
  logic [X_BITS-1:0] col;
  logic [Y_BITS-1:0] row;

  vpu_span_counter #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_span (
    .clk     (clk),
    .rst_n   (reset),
    .load    (load),
    .start_x (cmd_x),
    .start_y (cmd_y),
    .width   (cmd_w),
    .height  (cmd_h),
    .step    (step),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  always_comb begin
    state_d   = state_q;
    color_d   = color_q;
`ifdef VPU_FILL_PATTERN_EN
    color2_d  = color2_q;
    pattern_d = pattern_q;
`endif
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          load    = 1'b1;
          color_d = cmd_color;
`ifdef VPU_FILL_PATTERN_EN
          color2_d  = cmd_color2;
          pattern_d = cmd_pattern;
`endif
          state_d = ((cmd_w == '0) || (cmd_h == '0)) ? DONE : FILL;
        end
      end
      FILL: begin
        // A handshake coinciding with abort still advances and counts as written.
        step = wr_ready;
        if (cmd_abort || (wr_ready && last)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      color_q   <= '0;
`ifdef VPU_FILL_PATTERN_EN
      color2_q  <= '0;
      pattern_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      color_q   <= color_d;
`ifdef VPU_FILL_PATTERN_EN
      color2_q  <= color2_d;
      pattern_q <= pattern_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign wr_valid  = (state_q == FILL);
  assign busy      = (state_q == FILL);
  assign done      = (state_q == DONE);
  assign wr_addr   = {row, col};

  always_comb begin
`ifdef VPU_FILL_PATTERN_EN
    wr_data = (pattern_q && (col[0] ^ row[0])) ? color2_q : color_q;
`else
    wr_data = color_q;
`endif
  end

endmodule

// File: tb/tb_vpu_rect_filler.sv
// Scoreboard bench for vpu_rect_filler; define VPU_FILL_PATTERN_EN to also cover checkerboard fill.
module tb_vpu_rect_filler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [3:0]  cmd_color = '0;
`ifdef VPU_FILL_PATTERN_EN
  logic [3:0]  cmd_color2 = '0;
  logic        cmd_pattern = 1'b0;
`endif
  logic        cmd_abort = 1'b0;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [15:0] wr_addr;
  logic [3:0]  wr_data;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vpu_rect_filler #(
    .X_BITS     (8),
    .Y_BITS     (8),
    .COLOR_BITS (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_w       (cmd_w),
    .cmd_h       (cmd_h),
    .cmd_color   (cmd_color),
`ifdef VPU_FILL_PATTERN_EN
    .cmd_color2  (cmd_color2),
    .cmd_pattern (cmd_pattern),
`endif
    .cmd_abort   (cmd_abort),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done)
  );

  // Reference raster order: rows outer, columns inner, each field wrapping on its own.
  task automatic push_expected(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                               input logic [7:0] h, input logic [3:0] c, input logic [3:0] c2,
                               input logic pat);
    logic [7:0] rr, cc;
    exp_t e;
    for (int r = 0; r < int'(h); r++) begin
      for (int k = 0; k < int'(w); k++) begin
        rr = y + 8'(r);
        cc = x + 8'(k);
        e.addr = {rr, cc};
        e.data = (pat && (rr[0] ^ cc[0])) ? c2 : c;
        sb.push_back(e);
      end
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic issue_cmd(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                           input logic [7:0] h, input logic [3:0] c, input logic [3:0] c2,
                           input logic pat);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
`ifdef VPU_FILL_PATTERN_EN
    cmd_color2 = c2; cmd_pattern = pat;
`endif
    push_expected(x, y, w, h, c, c2, pat);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    n_cmp++;
    if ({cmd_ready, wr_valid, busy, done} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 1000", {cmd_ready, wr_valid, busy, done});
    end
    n_cmp++;
    if ({wr_addr, wr_data} !== 20'h0) begin
      n_bad++; $display("FAIL reset_payload: got %h want 00000", {wr_addr, wr_data});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Full-throughput fill: one write per cycle, then a single done cycle, then idle.
  task automatic test_fill(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                           input logic [7:0] h, input logic [3:0] c, input logic [3:0] c2,
                           input logic pat);
    exp_t e;
    wr_ready = 1'b1;
    issue_cmd(x, y, w, h, c, c2, pat);
    for (int i = 0; i < int'(w) * int'(h); i++) begin
      n_cmp++;
      if (wr_valid !== 1'b1) begin
        n_bad++; $display("FAIL fill_valid[%0d]: got %b want 1", i, wr_valid);
      end
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++; $display("FAIL fill_sb_empty[%0d]: got empty want entry", i);
      end else begin
        e = sb.pop_front();
        if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
          n_bad++;
          $display("FAIL fill_write[%0d]: got addr %h data %h want addr %h data %h",
                   i, wr_addr, wr_data, e.addr, e.data);
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({wr_valid, busy, done, cmd_ready} !== 4'b0010) begin
      n_bad++; $display("FAIL fill_done: got %b want 0010", {wr_valid, busy, done, cmd_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({wr_valid, done, cmd_ready} !== 3'b001) begin
      n_bad++; $display("FAIL fill_idle: got %b want 001", {wr_valid, done, cmd_ready});
    end
  endtask

  task automatic test_zero_size;
    logic [7:0] ws [2];
    logic [7:0] hs [2];
    ws[0] = 8'd0; hs[0] = 8'd7;
    ws[1] = 8'd5; hs[1] = 8'd0;
    for (int k = 0; k < 2; k++) begin
      issue_cmd(8'd3, 8'd4, ws[k], hs[k], 4'd6, 4'd0, 1'b0);
      n_cmp++;
      if ({wr_valid, done, cmd_ready} !== 3'b010) begin
        n_bad++; $display("FAIL zero_done[%0d]: got %b want 010", k, {wr_valid, done, cmd_ready});
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({wr_valid, done, cmd_ready} !== 3'b001) begin
        n_bad++; $display("FAIL zero_idle[%0d]: got %b want 001", k, {wr_valid, done, cmd_ready});
      end
      n_cmp++;
      if (sb.size() != 0) begin
        n_bad++; $display("FAIL zero_sb: got %0d entries want 0", sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t        e;
    int          hs_cnt = 0;
    bit          done_seen = 0;
    bit          prev_stall = 0;
    logic [15:0] pa = '0;
    logic [3:0]  pd = '0;
    issue_cmd(8'd100, 8'd3, 8'd4, 8'd4, 4'd7, 4'd0, 1'b0);
    for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      wr_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        n_cmp++;
        if (wr_valid !== 1'b1 || wr_addr !== pa || wr_data !== pd) begin
          n_bad++;
          $display("FAIL bp_stable: got v %b addr %h data %h want v 1 addr %h data %h",
                   wr_valid, wr_addr, wr_data, pa, pd);
        end
      end
      if (done) begin
        done_seen = 1;
      end else if (wr_valid && wr_ready) begin
        hs_cnt++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL bp_extra_write: got addr %h want none", wr_addr);
        end else begin
          e = sb.pop_front();
          if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
            n_bad++;
            $display("FAIL bp_write: got addr %h data %h want addr %h data %h",
                     wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      prev_stall = wr_valid && !wr_ready;
      pa = wr_addr;
      pd = wr_data;
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    n_cmp++;
    if (hs_cnt != 16 || !done_seen) begin
      n_bad++; $display("FAIL bp_count: got %0d handshakes done %0d want 16 done 1", hs_cnt, done_seen);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_idle: got %b want 1", cmd_ready);
    end
    sb.delete();
  endtask

  task automatic test_abort;
    exp_t e;
    wr_ready = 1'b1;
    issue_cmd(8'd0, 8'd5, 8'd8, 8'd1, 4'd2, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      e = sb.pop_front();
      if (wr_valid !== 1'b1 || {wr_addr, wr_data} !== {e.addr, e.data}) begin
        n_bad++;
        $display("FAIL abort_write[%0d]: got v %b addr %h data %h want v 1 addr %h data %h",
                 i, wr_valid, wr_addr, wr_data, e.addr, e.data);
      end
      if (i == 2) cmd_abort = 1'b1;
      @(posedge clk); #1;
    end
    cmd_abort = 1'b0;
    n_cmp++;
    if ({wr_valid, done} !== 2'b01) begin
      n_bad++; $display("FAIL abort_done: got %b want 01", {wr_valid, done});
    end
    n_cmp++;
    if (sb.size() != 5) begin
      n_bad++; $display("FAIL abort_count: got %0d unwritten want 5", sb.size());
    end
    sb.delete();
    // Abort while idle must not disturb the idle state.
    @(posedge clk); #1;
    cmd_abort = 1'b1;
    @(posedge clk); #1;
    cmd_abort = 1'b0;
    n_cmp++;
    if ({wr_valid, done, cmd_ready} !== 3'b001) begin
      n_bad++; $display("FAIL abort_idle: got %b want 001", {wr_valid, done, cmd_ready});
    end
  endtask

  task automatic test_back_to_back;
    test_fill(8'd1, 8'd1, 8'd2, 8'd1, 4'd3, 4'd0, 1'b0);
    test_fill(8'd7, 8'd9, 8'd1, 8'd2, 4'd12, 4'd0, 1'b0);
  endtask

  task automatic test_reset_midfill;
    int bad = 0;
    issue_cmd(8'd40, 8'd40, 8'd5, 8'd5, 4'd1, 4'd0, 1'b0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({wr_valid, busy, done, cmd_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL rst_mid: got %b want 0001", {wr_valid, busy, done, cmd_ready});
    end
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done || wr_valid) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL rst_no_done: got %0d active cycles want 0", bad);
    end
  endtask

`ifdef VPU_FILL_PATTERN_EN
  task automatic test_pattern;
    logic [3:0] want [4];
    logic [3:0] got [4];
    want[0] = 4'd1; want[1] = 4'd9; want[2] = 4'd9; want[3] = 4'd1;
    wr_ready = 1'b1;
    issue_cmd(8'd0, 8'd0, 8'd2, 8'd2, 4'd1, 4'd9, 1'b1);
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      got[i] = wr_data;
      n_cmp++;
      if (wr_valid !== 1'b1 || got[i] !== want[i]) begin
        n_bad++; $display("FAIL pattern[%0d]: got v %b data %h want v 1 data %h", i, wr_valid, got[i], want[i]);
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_fill(8'd10, 8'd20, 8'd3, 8'd2, 4'd5, 4'd0, 1'b0);
    test_fill(8'd254, 8'd255, 8'd4, 8'd2, 4'd11, 4'd0, 1'b0);
    test_zero_size();
    test_backpressure();
    test_abort();
    test_back_to_back();
`ifdef VPU_FILL_PATTERN_EN
    test_pattern();
`endif
    test_reset_midfill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vpu_rect_filler.md
VPU_RECT_FILLER -- requirements
Module: vpu_rect_filler

Interface
REQ-001 The block SHALL have parameter X_BITS, default 8, giving the column address width (one row of 2^X_BITS pixels).
REQ-002 The block SHALL have parameter Y_BITS, default 8, giving the row address width.
REQ-003 The block SHALL have parameter COLOR_BITS, default 4, giving the pixel width.
REQ-004 The block SHALL have port clk, in, 1, the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port reset, in, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port cmd_valid, in, 1, a fill command is presented.
REQ-007 The block SHALL have port cmd_ready, out, 1, the block accepts a command.
REQ-008 The block SHALL have ports cmd_x and cmd_w, in, X_BITS, giving the start column and the width in pixels.
REQ-009 The block SHALL have ports cmd_y and cmd_h, in, Y_BITS, giving the start row and the height in rows.
REQ-010 The block SHALL have port cmd_color, in, COLOR_BITS, the fill colour.
REQ-011 The block SHALL have port cmd_abort, in, 1, which terminates the active fill.
REQ-012 The block SHALL have port wr_valid, out, 1, a pixel write is presented to the frame buffer.
REQ-013 The block SHALL have port wr_ready, in, 1, the frame buffer accepts the write.
REQ-014 The block SHALL have port wr_addr, out, Y_BITS+X_BITS, the write address {row, col}, matching the linear scanout order.
REQ-015 The block SHALL have port wr_data, out, COLOR_BITS, the pixel value.
REQ-016 The block SHALL have port busy, out, 1, asserted while in FILL.
REQ-017 The block SHALL have port done, out, 1, a one-cycle pulse when a fill completes or is aborted.

Function
REQ-018 The block SHALL implement states IDLE, FILL and DONE.
REQ-019 cmd_ready SHALL be 1 only in IDLE.
REQ-020 A command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1, and all cmd_* fields SHALL be captured on that edge.
REQ-021 On acceptance with cmd_w=0 or cmd_h=0, the block SHALL go to DONE and issue no write.
REQ-022 On any other acceptance, the block SHALL go to FILL, and wr_valid SHALL be 1 on the cycle after acceptance, with wr_addr={cmd_y, cmd_x}.
REQ-023 wr_valid SHALL stay 1 and wr_addr/wr_data SHALL stay stable until a cycle with wr_valid=1 and wr_ready=1 (a handshake).
REQ-024 Each handshake SHALL advance the column by 1; after cmd_w handshakes in a row, the column SHALL reload cmd_x and the row SHALL advance by 1.
REQ-025 Column and row arithmetic SHALL wrap modulo 2^X_BITS and 2^Y_BITS; a span crossing the edge SHALL continue at 0 with no carry into the other field.
REQ-026 A handshake in FILL SHALL complete at most one pixel per cycle; with wr_ready held at 1, the block SHALL issue cmd_w*cmd_h writes on consecutive cycles.
REQ-027 On the handshake of the final pixel, the block SHALL go to DONE, with wr_valid=0 on the following cycle.
REQ-028 In DONE, done SHALL be 1 for exactly one cycle, followed by IDLE, and a new command SHALL be acceptable on the IDLE cycle.
REQ-029 cmd_abort=1 in FILL SHALL force DONE on the next edge; a handshake in the same cycle SHALL still count as written, and no further write SHALL be issued.
REQ-030 cmd_abort SHALL be ignored in IDLE and in DONE.
REQ-031 Without the configuration feature, wr_data SHALL equal cmd_color.

Reset
REQ-032 While reset=0, the state SHALL be IDLE and cmd_ready=1, with wr_valid, busy and done at 0 and wr_addr and wr_data at 0.
REQ-033 Reset asserted mid-fill SHALL drop wr_valid immediately (asynchronously), with no done pulse.

Configuration
REQ-034 With macro VPU_FILL_PATTERN_EN defined, the block SHALL add input ports cmd_color2 (COLOR_BITS) and cmd_pattern (1), captured with the command.
REQ-035 With VPU_FILL_PATTERN_EN defined and cmd_pattern=1, wr_data SHALL be cmd_color2 when (col XOR row) bit 0 is 1, and cmd_color otherwise (checkerboard).
REQ-036 Without VPU_FILL_PATTERN_EN, those ports SHALL be absent and the behaviour SHALL be solid fill only.

Structure
REQ-037 Shared package vpu_pkg SHALL hold the state enum (IDLE/FILL/DONE) and the default X_BITS/Y_BITS/COLOR_BITS constants.
REQ-038 One sub-module, vpu_span_counter, SHALL hold the column/row counters with reload, wrap and last-pixel detection.

Verification
REQ-039 The bench SHALL check: x=10,y=20,w=3,h=2,color=5, wr_ready=1 -> 6 writes to 0x140A,0x140B,0x140C,0x150A,0x150B,0x150C, data 5, then done one cycle later.
REQ-040 The bench SHALL check: x=254,y=255,w=4,h=2 -> addrs 0xFFFE,0xFFFF,0xFF00,0xFF01,0x00FE,0x00FF,0x0000,0x0001.
REQ-041 The bench SHALL check: w=0,h=7 -> no wr_valid, done on the cycle after acceptance, cmd_ready back the cycle after that.
REQ-042 The bench SHALL check: wr_ready toggled randomly on a 4x4 fill -> exactly 16 handshakes, and payload stable while stalled.
REQ-043 The bench SHALL check: cmd_abort during the 3rd handshake of an 8x1 fill -> exactly 3 writes, done pulse, then IDLE.
REQ-044 The bench SHALL check: with VPU_FILL_PATTERN_EN, a 2x2 fill at (0,0), color=1, color2=9, pattern=1 -> data 1,9,9,1.
